xres_pad_ctrl: RTL and testbench

Core-side controller for the external-reset pad: the driving and consuming end of the pad's control/return interface.
- Sequences the pad enables after power-on.
- Synchronises and digitally debounces the pad's XRES return.
- Generates the filtered value fed back to the pad's FILT_IN_H input.
- Produces a stretched, glitch-free system reset for the core.
- Sits between the XRES pad instance and the top-level reset tree.

---
 rtl/xres_pad_ctrl_pkg.sv | 24 ++
 rtl/xres_debounce.sv | 68 ++++++
 rtl/xres_pad_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_xres_pad_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xres_pad_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// xres_pad_ctrl_pkg
// Shared definitions for the external-reset pad controller:
//   state_t   - controller FSM encoding (also exported on state_o)
//   CNT_W_DEF - default width of the internal counters
//   sat_inc   - saturating increment used by the glitch counter
// -----------------------------------------------------------------------------
package xres_pad_ctrl_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        PWRUP  = 2'd0,
        ENABLE = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    // Increment v by one but never past max_val.
    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_val);
        return (v >= max_val) ? max_val : v + 1;
    endfunction

endpackage

// File: rtl/xres_debounce.sv
// -----------------------------------------------------------------------------
// xres_debounce
// Two-flop synchroniser plus digital debounce for the pad XRES return.
// The filtered level only moves after the synchronised input has disagreed
// with it for FILT_CYCLES consecutive cycles.
//
// Ports:
//   clk, rst   - core clock, asynchronous active-high reset
//   glitch     - (only with XRES_PAD_CTRL_GLITCH_CNT_EN) one-cycle pulse when
//                a disagreement run ends before reaching FILT_CYCLES
//   xres_h_n   - raw pad return, asynchronous to clk
//   filt       - debounced level (registered)
//   filt_fall  - filt will drop from 1 to 0 on the coming edge
// -----------------------------------------------------------------------------
module xres_debounce
    import xres_pad_ctrl_pkg::*;
#(
    parameter int FILT_CYCLES = 16,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
`ifdef XRES_PAD_CTRL_GLITCH_CNT_EN
    output logic glitch,
`endif
    input  logic xres_h_n,
    output logic filt,
    output logic filt_fall
);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             done;

    assign differ = (sync_q != filt);
    // Current cycle is the FILT_CYCLES-th consecutive disagreement.
    assign done   = differ && (cnt == CNT_W'(FILT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            filt   <= 1'b0;
            cnt    <= '0;
        end else begin
            meta_q <= xres_h_n;
            sync_q <= meta_q;
            if (!differ) begin
                cnt <= '0;
            end else if (done) begin
                filt <= sync_q;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign filt_fall = done && filt;

`ifdef XRES_PAD_CTRL_GLITCH_CNT_EN
    // Input came back to the filtered level part-way through a run.
    assign glitch = !differ && (cnt != '0);
`endif

endmodule

// File: rtl/xres_pad_ctrl.sv
// -----------------------------------------------------------------------------
// xres_pad_ctrl
// Core-side controller for the external-reset pad. Sequences the pad enables
// after power-on, debounces the XRES return (fed back on FILT_IN_H), and
// produces a stretched active-low system reset.
//
// Optional feature macro: XRES_PAD_CTRL_GLITCH_CNT_EN
//   defined   - glitch_cnt counts rejected pulses, saturating at all-ones
//   undefined - glitch_cnt is tied to 0, no counter flops
//
// Ports:
//   clk, rst              - core clock, asynchronous active-high reset
//   xres_h_n              - pad XRES return (asynchronous)
//   filt_sel_req          - selects pad digital filter path (INP_SEL_H)
//   sw_disable_pullup     - request to disable the pad pull-up
//   pad_enable_h          - pad ENABLE_H
//   pad_enable_vddio      - pad ENABLE_VDDIO
//   pad_en_vddio_sig_h    - pad EN_VDDIO_SIG_H
//   pad_inp_sel_h         - pad INP_SEL_H
//   pad_filt_in_h         - pad FILT_IN_H (debounced level)
//   pad_disable_pullup_h  - pad DISABLE_PULLUP_H
//   sys_rst_n             - active-low core reset
//   state_o               - FSM state (0 PWRUP, 1 ENABLE, 2 SETTLE, 3 RUN)
//   glitch_cnt            - saturating count of rejected pulses
//
// Handshake: none; all inputs are levels, all outputs are registered levels.
// -----------------------------------------------------------------------------
module xres_pad_ctrl
    import xres_pad_ctrl_pkg::*;
#(
    parameter int FILT_CYCLES    = 16,
    parameter int STRETCH_CYCLES = 64,
    parameter int SETTLE_CYCLES  = 8,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xres_h_n,
    input  logic             filt_sel_req,
    input  logic             sw_disable_pullup,
    output logic             pad_enable_h,
    output logic             pad_enable_vddio,
    output logic             pad_en_vddio_sig_h,
    output logic             pad_inp_sel_h,
    output logic             pad_filt_in_h,
    output logic             pad_disable_pullup_h,
    output logic             sys_rst_n,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] glitch_cnt
);

    state_t           state;
    state_t           next_state;
    logic             en_h_d;
    logic             en_vddio_d;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] stretch_cnt;
    logic             filt;
    logic             filt_fall;

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
`ifdef XRES_PAD_CTRL_GLITCH_CNT_EN
    logic glitch;
`endif

    xres_debounce #(
        .FILT_CYCLES (FILT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
`ifdef XRES_PAD_CTRL_GLITCH_CNT_EN
        .glitch    (glitch),
`endif
        .xres_h_n  (xres_h_n),
        .filt      (filt),
        .filt_fall (filt_fall)
    );

    assign pad_filt_in_h = filt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PWRUP;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            PWRUP:   next_state = ENABLE;
            ENABLE:  next_state = SETTLE;
            SETTLE:  if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) next_state = RUN;
            RUN:     next_state = RUN;
            default: next_state = PWRUP;
        endcase
        // Enables are derived from the next state so they rise on the same
        // edge as the state they belong to; VDDIO and its signal enable share
        // one term so they can never disagree.
        en_h_d     = (next_state != PWRUP);
        en_vddio_d = (next_state == SETTLE) || (next_state == RUN);
    end

    assign state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Pad control outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_enable_h         <= 1'b0;
            pad_enable_vddio     <= 1'b0;
            pad_en_vddio_sig_h   <= 1'b0;
            pad_inp_sel_h        <= 1'b0;
            pad_disable_pullup_h <= 1'b0;
        end else begin
            pad_enable_h         <= en_h_d;
            pad_enable_vddio     <= en_vddio_d;
            pad_en_vddio_sig_h   <= en_vddio_d;
            pad_inp_sel_h        <= (state == RUN) ? filt_sel_req : 1'b0;
            pad_disable_pullup_h <= (state == RUN) ? sw_disable_pullup : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Reset stretcher
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stretch_cnt <= '0;
            sys_rst_n   <= 1'b0;
        end else if ((state != RUN) || !filt) begin
            stretch_cnt <= '0;
            sys_rst_n   <= 1'b0;
        end else if (!sys_rst_n) begin
            if (stretch_cnt == CNT_W'(STRETCH_CYCLES - 1)) begin
                // A filt fall on the completing cycle keeps reset asserted.
                if (!filt_fall) sys_rst_n <= 1'b1;
            end else begin
                stretch_cnt <= stretch_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Glitch counter
    // ------------------------------------------------------------------
`ifdef XRES_PAD_CTRL_GLITCH_CNT_EN
    localparam int unsigned GLITCH_MAX = (1 << CNT_W) - 1;
    logic [CNT_W-1:0] glitch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (glitch) begin
            glitch_q <= CNT_W'(sat_inc(32'(glitch_q), GLITCH_MAX));
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_xres_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xres_pad_ctrl
// Bench for xres_pad_ctrl with FILT=16, SETTLE=8, STRETCH=64. A behavioural
// model derives the expected outputs from the cycle count since reset release
// and a sliding window of synchronised input samples; a compare process checks
// every output on each falling edge, and the directed sequence pins key
// timing points with literal expectations.
// -----------------------------------------------------------------------------
module tb_xres_pad_ctrl;

    localparam int FILT    = 16;
    localparam int STRETCH = 64;
    localparam int SETTLE  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       xres_h_n = 1'b1;
    logic       filt_sel_req = 1'b0;
    logic       sw_disable_pullup = 1'b0;
    logic       pad_enable_h;
    logic       pad_enable_vddio;
    logic       pad_en_vddio_sig_h;
    logic       pad_inp_sel_h;
    logic       pad_filt_in_h;
    logic       pad_disable_pullup_h;
    logic       sys_rst_n;
    logic [1:0] state_o;
    logic [7:0] glitch_cnt;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    xres_pad_ctrl #(
        .FILT_CYCLES    (FILT),
        .STRETCH_CYCLES (STRETCH),
        .SETTLE_CYCLES  (SETTLE),
        .CNT_W          (8)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .xres_h_n             (xres_h_n),
        .filt_sel_req         (filt_sel_req),
        .sw_disable_pullup    (sw_disable_pullup),
        .pad_enable_h         (pad_enable_h),
        .pad_enable_vddio     (pad_enable_vddio),
        .pad_en_vddio_sig_h   (pad_en_vddio_sig_h),
        .pad_inp_sel_h        (pad_inp_sel_h),
        .pad_filt_in_h        (pad_filt_in_h),
        .pad_disable_pullup_h (pad_disable_pullup_h),
        .sys_rst_n            (sys_rst_n),
        .state_o              (state_o),
        .glitch_cnt           (glitch_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase is a pure function of edges since reset release.
    function automatic logic [1:0] st_of(input int c);
        if (c >= 2 + SETTLE) return 2'd3;
        if (c >= 2)          return 2'd2;
        if (c >= 1)          return 2'd1;
        return 2'd0;
    endfunction

    int              m_cyc;
    int              m_run;      // consecutive RUN edges with filt high
    logic            m_s1, m_sync, m_filt, m_sys, m_inp, m_pu;
    logic [FILT-1:0] m_win;      // last FILT synchronised samples, newest in bit 0
    logic [7:0]      m_gl;

    logic [FILT-1:0] w_n;
    logic            filt_n;
    logic            glitch_n;
    int              run_n;
    logic            run_ph;
    logic            sys_n;

    always_comb begin
        w_n      = {m_win[FILT-2:0], m_sync};
        filt_n   = m_filt;
        if (m_filt ? (w_n == '0) : (w_n == '1)) filt_n = ~m_filt;
        glitch_n = (m_sync == m_filt) && (m_win[0] != m_filt);
        run_ph   = (st_of(m_cyc) == 2'd3);
        run_n    = (run_ph && m_filt) ? m_run + 1 : 0;
        sys_n    = run_ph && m_filt && (m_sys || ((run_n >= STRETCH) && filt_n));
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc  <= 0;
            m_run  <= 0;
            m_s1   <= 1'b0;
            m_sync <= 1'b0;
            m_filt <= 1'b0;
            m_sys  <= 1'b0;
            m_inp  <= 1'b0;
            m_pu   <= 1'b0;
            m_win  <= '0;
            m_gl   <= 8'd0;
        end else begin
            m_cyc  <= (m_cyc < 100000) ? m_cyc + 1 : m_cyc;
            m_run  <= run_n;
            m_s1   <= xres_h_n;
            m_sync <= m_s1;
            m_win  <= w_n;
            m_filt <= filt_n;
            m_sys  <= sys_n;
            m_inp  <= run_ph ? filt_sel_req : 1'b0;
            m_pu   <= run_ph ? sw_disable_pullup : 1'b0;
`ifdef XRES_PAD_CTRL_GLITCH_CNT_EN
            if (glitch_n && (m_gl != 8'hff)) m_gl <= m_gl + 8'd1;
`endif
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("state_o",     32'(state_o),              32'(st_of(m_cyc)));
        chk("enable_h",    32'(pad_enable_h),         32'(m_cyc >= 1));
        chk("enable_vddio",32'(pad_enable_vddio),     32'(m_cyc >= 2));
        chk("en_sig_h",    32'(pad_en_vddio_sig_h),   32'(m_cyc >= 2));
        chk("inp_sel",     32'(pad_inp_sel_h),        32'(m_inp));
        chk("dis_pullup",  32'(pad_disable_pullup_h), 32'(m_pu));
        chk("filt_in",     32'(pad_filt_in_h),        32'(m_filt));
        chk("sys_rst_n",   32'(sys_rst_n),            32'(m_sys));
        chk("glitch_cnt",  32'(glitch_cnt),           32'(m_gl));
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic low_pulse(input int n);
        xres_h_n = 1'b0;
        step(n);
        xres_h_n = 1'b1;
    endtask

    task automatic check_all_reset(input string tag);
        chk({tag, "_state"},   32'(state_o),              32'd0);
        chk({tag, "_en_h"},    32'(pad_enable_h),         32'd0);
        chk({tag, "_vddio"},   32'(pad_enable_vddio),     32'd0);
        chk({tag, "_sig"},     32'(pad_en_vddio_sig_h),   32'd0);
        chk({tag, "_inp"},     32'(pad_inp_sel_h),        32'd0);
        chk({tag, "_pu"},      32'(pad_disable_pullup_h), 32'd0);
        chk({tag, "_filt"},    32'(pad_filt_in_h),        32'd0);
        chk({tag, "_sys"},     32'(sys_rst_n),            32'd0);
        chk({tag, "_glitch"},  32'(glitch_cnt),           32'd0);
    endtask

    // Release reset at a falling edge (call that edge 0) and pin the
    // power-up timeline with literal expectations.
    task automatic power_up_seq;
        xres_h_n          = 1'b1;
        filt_sel_req      = 1'b0;
        sw_disable_pullup = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("pu_c1_state", 32'(state_o), 32'd1);
        chk("pu_c1_en_h",  32'(pad_enable_h), 32'd1);
        chk("pu_c1_vddio", 32'(pad_enable_vddio), 32'd0);
        step(1);
        chk("pu_c2_state", 32'(state_o), 32'd2);
        chk("pu_c2_vddio", 32'(pad_enable_vddio), 32'd1);
        chk("pu_c2_sig",   32'(pad_en_vddio_sig_h), 32'd1);
        filt_sel_req      = 1'b1;
        sw_disable_pullup = 1'b1;
        step(7);
        chk("pu_c9_state", 32'(state_o), 32'd2);
        chk("pu_c9_inp",   32'(pad_inp_sel_h), 32'd0);
        step(1);
        chk("pu_c10_state", 32'(state_o), 32'd3);
        chk("pu_c10_inp",   32'(pad_inp_sel_h), 32'd0);
        chk("pu_c10_pu",    32'(pad_disable_pullup_h), 32'd0);
        step(1);
        chk("pu_c11_inp", 32'(pad_inp_sel_h), 32'd1);
        chk("pu_c11_pu",  32'(pad_disable_pullup_h), 32'd1);
        step(6);
        chk("pu_c17_filt", 32'(pad_filt_in_h), 32'd0);
        step(1);
        chk("pu_c18_filt", 32'(pad_filt_in_h), 32'd1);
        step(63);
        chk("pu_c81_sys", 32'(sys_rst_n), 32'd0);
        step(1);
        chk("pu_c82_sys", 32'(sys_rst_n), 32'd1);
        filt_sel_req = 1'b0;
        step(1);
        chk("sel_prop_inp", 32'(pad_inp_sel_h), 32'd0);
        chk("sel_prop_pu",  32'(pad_disable_pullup_h), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] e;
`ifdef XRES_PAD_CTRL_GLITCH_CNT_EN
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd255);
`else
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd0);
`endif
        #1 rst = 1'b1;
        step(3);
        check_all_reset("rst0");

        power_up_seq();

        // Short 10-cycle pulse is rejected
        low_pulse(10);
        step(30);
        chk("gl10_filt", 32'(pad_filt_in_h), 32'd1);
        chk("gl10_sys",  32'(sys_rst_n), 32'd1);
        e = exp_q.pop_front();
        chk("gl10_cnt",  32'(glitch_cnt), 32'(e));

        // 20-cycle pulse passes the filter
        xres_h_n = 1'b0;
        step(17);
        chk("p20_e17_filt", 32'(pad_filt_in_h), 32'd1);
        step(1);
        chk("p20_e18_filt", 32'(pad_filt_in_h), 32'd0);
        chk("p20_e18_sys",  32'(sys_rst_n), 32'd1);
        step(1);
        chk("p20_e19_sys",  32'(sys_rst_n), 32'd0);
        step(1);
        xres_h_n = 1'b1;
        step(17);
        chk("p20_r17_filt", 32'(pad_filt_in_h), 32'd0);
        step(1);
        chk("p20_r18_filt", 32'(pad_filt_in_h), 32'd1);
        step(63);
        chk("p20_r81_sys", 32'(sys_rst_n), 32'd0);
        step(1);
        chk("p20_r82_sys", 32'(sys_rst_n), 32'd1);

        // 300 rejected glitches saturate the counter
        for (int i = 0; i < 300; i++) begin
            low_pulse(10);
            step(10);
        end
        step(5);
        e = exp_q.pop_front();
        chk("gl_sat_cnt", 32'(glitch_cnt), 32'(e));
        chk("gl_sat_sys", 32'(sys_rst_n), 32'd1);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_reset("async");
        step(3);
        power_up_seq();
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
